// File: rtl/spi_bridge_pkg.sv
// Shared constants for the SPI/AHB FIFO bridge: register offsets, launch FSM states
// and STATUS bit positions.
package spi_bridge_pkg;

  localparam logic [3:0] ADDR_TX   = 4'h0;
  localparam logic [3:0] ADDR_RX   = 4'h4;
  localparam logic [3:0] ADDR_STAT = 4'h8;
  localparam logic [3:0] ADDR_CTRL = 4'hC;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_XFER   = 2'd2
  } state_e;

  localparam int STAT_BUSY     = 0;
  localparam int STAT_TX_FULL  = 1;
  localparam int STAT_TX_EMPTY = 2;
  localparam int STAT_RX_FULL  = 3;
  localparam int STAT_RX_EMPTY = 4;
  localparam int STAT_TX_OVF   = 5;
  localparam int STAT_RX_OVF   = 6;
  localparam int STAT_RX_UDF   = 7;
  localparam int STAT_TX_CNT   = 8;
  localparam int STAT_RX_CNT   = 16;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count and flush. A push alongside a pop is accepted
// even when full; a push during flush lands as the sole entry.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = DEPTH[CW-1:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_addr;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push & (~full | pop | flush);
    do_pop   = pop & ~empty;
    wr_addr  = flush ? '0 : wr_ptr_q;
    wr_ptr_d = flush ? AW'(do_push) : wr_ptr_q + AW'(do_push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(do_pop);
    count_d  = flush ? CW'(do_push) : count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_addr] <= wdata;
  end

endmodule

// File: rtl/spi_ahb_fifo_bridge.sv
// AHB-side register block feeding a byte-serial SPI engine through TX/RX FIFOs,
// with a launch FSM driving the ready_send/busy handshake and sticky error flags.
module spi_ahb_fifo_bridge
  import spi_bridge_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hsel,
  input  logic              hwrite,
  input  logic [31:0]       haddr,
  input  logic [31:0]       hwdata,
  output logic [31:0]       hrdata,
  input  logic [DATA_W-1:0] spi_data_out,
  input  logic              spi_busy,
  output logic [DATA_W-1:0] spi_data_in,
  output logic              spi_ready_send
);

  localparam int TX_CW = $clog2(TX_DEPTH) + 1;
  localparam int RX_CW = $clog2(RX_DEPTH) + 1;

  logic [3:0]        addr;
  logic              wr_tx, rd_rx, wr_stat, wr_ctrl;
  logic              tx_push, tx_full, tx_empty;
  logic [TX_CW-1:0]  tx_count;
  logic [DATA_W-1:0] tx_head;
  logic              rx_push, rx_pop, rx_full, rx_empty;
  logic [RX_CW-1:0]  rx_count;
  logic [DATA_W-1:0] rx_head;

  state_e            state_q, state_d;
  logic              launch, ack, capture;
  logic              ready_send_q;
  logic [DATA_W-1:0] data_in_q;

  logic              flush_q, rx_en_q;
  logic              tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d, rx_udf_q, rx_udf_d;
  logic [31:0]       status;
  logic              unused_bits;

  assign unused_bits = ^{haddr[31:4], hwdata[31:8]};

  assign addr    = haddr[3:0];
  assign wr_tx   = hsel &  hwrite & (addr == ADDR_TX);
  assign rd_rx   = hsel & ~hwrite & (addr == ADDR_RX);
  assign wr_stat = hsel &  hwrite & (addr == ADDR_STAT);
  assign wr_ctrl = hsel &  hwrite & (addr == ADDR_CTRL);

  // Fullness is sampled before the launch pop, and writes landing on a flush cycle are discarded.
  assign tx_push = wr_tx & ~tx_full & ~flush_q;
  assign rx_push = capture & rx_en_q;
  assign rx_pop  = rd_rx & ~rx_empty;

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (launch),
    .flush (flush_q),
    .wdata (hwdata[DATA_W-1:0]),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count),
    .head  (tx_head)
  );

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rx_pop),
    .flush (flush_q),
    .wdata (spi_data_out),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count),
    .head  (rx_head)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (!tx_empty && !spi_busy) state_d = S_LAUNCH;
      S_LAUNCH: if (spi_busy)               state_d = S_XFER;
      S_XFER:   if (!spi_busy)              state_d = S_IDLE;
      default:                              state_d = S_IDLE;
    endcase
  end

  always_comb begin
    launch  = (state_q == S_IDLE)   & ~tx_empty & ~spi_busy;
    ack     = (state_q == S_LAUNCH) &  spi_busy;
    capture = (state_q == S_XFER)   & ~spi_busy;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_send_q <= 1'b0;
      data_in_q    <= '0;
    end else if (launch) begin
      ready_send_q <= 1'b1;
      data_in_q    <= tx_head;
    end else if (ack) begin
      ready_send_q <= 1'b0;
    end
  end

  assign spi_ready_send = ready_send_q;
  assign spi_data_in    = data_in_q;

  // A new error event in the same cycle as a write-1-to-clear keeps the flag set.
  always_comb begin
    tx_ovf_d = (tx_ovf_q & ~(wr_stat & hwdata[STAT_TX_OVF])) | (wr_tx & tx_full & ~flush_q);
    rx_ovf_d = (rx_ovf_q & ~(wr_stat & hwdata[STAT_RX_OVF])) |
               (rx_push & rx_full & ~rx_pop & ~flush_q);
    rx_udf_d = (rx_udf_q & ~(wr_stat & hwdata[STAT_RX_UDF])) | (rd_rx & rx_empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_q  <= 1'b0;
      rx_en_q  <= 1'b1;
      tx_ovf_q <= 1'b0;
      rx_ovf_q <= 1'b0;
      rx_udf_q <= 1'b0;
    end else begin
      flush_q  <= wr_ctrl & hwdata[1];
      if (wr_ctrl) rx_en_q <= hwdata[0];
      tx_ovf_q <= tx_ovf_d;
      rx_ovf_q <= rx_ovf_d;
      rx_udf_q <= rx_udf_d;
    end
  end

  always_comb begin
    status                      = '0;
    status[STAT_BUSY]           = (state_q != S_IDLE);
    status[STAT_TX_FULL]        = tx_full;
    status[STAT_TX_EMPTY]       = tx_empty;
    status[STAT_RX_FULL]        = rx_full;
    status[STAT_RX_EMPTY]       = rx_empty;
    status[STAT_TX_OVF]         = tx_ovf_q;
    status[STAT_RX_OVF]         = rx_ovf_q;
    status[STAT_RX_UDF]         = rx_udf_q;
    status[STAT_TX_CNT +: 8]    = 8'(tx_count);
    status[STAT_RX_CNT +: 8]    = 8'(rx_count);
  end

  always_comb begin
    hrdata = '0;
    case (addr)
      ADDR_RX:   hrdata = rx_empty ? '0 : 32'(rx_head);
      ADDR_STAT: hrdata = status;
      ADDR_CTRL: hrdata = {31'b0, rx_en_q};
      default:   hrdata = '0;
    endcase
  end

endmodule

// File: tb/tb_spi_ahb_fifo_bridge.sv
// Scoreboard bench: an 8-bit/depth-4 bridge and a 16-bit/TX-depth-8 bridge, each
// paired with a behavioural SPI engine; monitors check reads and launches against queues.
module tb_spi_ahb_fifo_bridge;
  import spi_bridge_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, hsel, hsel16, hwrite;
  logic [31:0] haddr, hwdata, hrdata, hrdata16;
  logic [7:0]  spi_data_out, spi_data_in;
  logic        spi_busy, spi_ready_send;
  logic [15:0] sdo16, sdi16;
  logic        busy16, rs16;

  spi_ahb_fifo_bridge #(.DATA_W(8), .TX_DEPTH(4), .RX_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .hsel(hsel), .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata),
    .hrdata(hrdata), .spi_data_out(spi_data_out), .spi_busy(spi_busy),
    .spi_data_in(spi_data_in), .spi_ready_send(spi_ready_send)
  );

  spi_ahb_fifo_bridge #(.DATA_W(16), .TX_DEPTH(8), .RX_DEPTH(4)) dut16 (
    .clk(clk), .rst(rst), .hsel(hsel16), .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata),
    .hrdata(hrdata16), .spi_data_out(sdo16), .spi_busy(busy16),
    .spi_data_in(sdi16), .spi_ready_send(rs16)
  );

  int n_cmp = 0, n_fail = 0, cyc = 0, xfers = 0, x16 = 0, last_fall = -1, busy_len = 8, tgt = 0;
  bit eng_hold = 1'b0, gap_en = 1'b0, rs_prev = 1'b0, rs16_prev = 1'b0;
  logic [31:0] exp_rd[$], exp_rd16[$], exp_l[$], exp_l16[$];
  logic [7:0]  resp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic wr(input bit s16, input logic [3:0] a, input logic [31:0] d);
    haddr = {28'h0, a}; hwdata = d; hwrite = 1'b1;
    if (s16) hsel16 = 1'b1; else hsel = 1'b1;
    @(posedge clk); #1;
    hsel = 1'b0; hsel16 = 1'b0; hwrite = 1'b0;
  endtask

  task automatic rd(input bit s16, input logic [3:0] a, input logic [31:0] e);
    if (s16) exp_rd16.push_back(e); else exp_rd.push_back(e);
    haddr = {28'h0, a}; hwrite = 1'b0;
    if (s16) hsel16 = 1'b1; else hsel = 1'b1;
    @(posedge clk); #1;
    hsel = 1'b0; hsel16 = 1'b0;
  endtask

  task automatic wait_n(input bit s16, input int n);
    for (int i = 0; i < 2000 && (s16 ? x16 : xfers) < n; i++) @(posedge clk);
    if ((s16 ? x16 : xfers) < n) fail_now("transfer_timeout");
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] word16(input int i);
    return 16'h8001 + 16'(i) * 16'h0F0F;
  endfunction

  // Engine model for the 8-bit bridge: optional hold keeps busy high while idle.
  initial begin : engine8
    spi_busy = 1'b0; spi_data_out = '0;
    forever begin
      @(posedge clk); #1;
      if (eng_hold) spi_busy = 1'b1;
      else if (spi_ready_send && !spi_busy) begin
        spi_busy = 1'b1;
        if (resp_q.size() > 0) spi_data_out = resp_q.pop_front();
        else spi_data_out = 8'h00;
        repeat (busy_len) @(posedge clk);
        #1;
        spi_busy = 1'b0; last_fall = cyc; xfers++;
      end else spi_busy = 1'b0;
    end
  end

  initial begin : engine16
    busy16 = 1'b0; sdo16 = '0;
    forever begin
      @(posedge clk); #1;
      if (rs16 && !busy16) begin
        busy16 = 1'b1; sdo16 = ~sdi16;
        repeat (2) @(posedge clk);
        #1;
        busy16 = 1'b0; x16++;
      end
    end
  end

  always @(negedge clk) begin : mon8
    if (spi_ready_send && !rs_prev) begin
      if (exp_l.size() == 0) fail_now("launch_unexpected");
      else check("launch_data", {24'h0, spi_data_in}, exp_l.pop_front());
      if (gap_en && last_fall >= 0) check("launch_gap", cyc - last_fall, 2);
    end
    if (!spi_ready_send && rs_prev && !rst) check("ready_end_on_busy", {31'h0, spi_busy}, 1);
    rs_prev = spi_ready_send;
    if (hsel && !hwrite) begin
      if (exp_rd.size() == 0) fail_now("read_unexpected");
      else check("read8", hrdata, exp_rd.pop_front());
    end
  end

  always @(negedge clk) begin : mon16
    if (rs16 && !rs16_prev) begin
      if (exp_l16.size() == 0) fail_now("launch16_unexpected");
      else check("launch16_data", {16'h0, sdi16}, exp_l16.pop_front());
    end
    rs16_prev = rs16;
    if (hsel16 && !hwrite) begin
      if (exp_rd16.size() == 0) fail_now("read16_unexpected");
      else check("read16", hrdata16, exp_rd16.pop_front());
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    rst = 1'b1; hsel = 1'b0; hsel16 = 1'b0; hwrite = 1'b0; haddr = '0; hwdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_ready_send", {31'h0, spi_ready_send}, 0);
    check("rst_data_in", {24'h0, spi_data_in}, 0);
    rd(0, ADDR_STAT, 32'h0000_0014);
    rd(0, ADDR_CTRL, 32'h0000_0001);
    rd(0, 4'h3, 32'h0);

    // Single word round trip.
    busy_len = 8;
    exp_l.push_back(32'hA5); resp_q.push_back(8'h3C);
    wr(0, ADDR_TX, 32'hFFFF_FFA5);
    @(posedge clk); #1;
    check("launch_latency", {31'h0, spi_ready_send}, 1);
    tgt += 1; wait_n(0, tgt);
    rd(0, ADDR_RX, 32'h3C);
    rd(0, ADDR_STAT, 32'h0000_0014);

    // TX overflow with the engine held busy, then back-to-back launches.
    busy_len = 3;
    eng_hold = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 1; i <= 5; i++) wr(0, ADDR_TX, 32'(i * 8'h11));
    for (int i = 1; i <= 4; i++) begin
      exp_l.push_back(32'(i * 8'h11)); resp_q.push_back(8'(8'h80 + i));
    end
    rd(0, ADDR_STAT, 32'h0000_0432);
    wr(0, ADDR_STAT, 32'h20);
    rd(0, ADDR_STAT, 32'h0000_0412);
    gap_en = 1'b1; last_fall = -1; eng_hold = 1'b0;
    tgt += 4; wait_n(0, tgt);
    gap_en = 1'b0;
    rd(0, ADDR_STAT, 32'h0004_000C);
    for (int i = 1; i <= 4; i++) rd(0, ADDR_RX, 32'(8'h80 + i));
    rd(0, ADDR_STAT, 32'h0000_0014);

    // RX overflow and underflow.
    for (int i = 1; i <= 5; i++) begin
      exp_l.push_back(32'(i)); resp_q.push_back(8'(8'h90 + i));
    end
    for (int i = 1; i <= 5; i++) wr(0, ADDR_TX, 32'(i));
    tgt += 5; wait_n(0, tgt);
    rd(0, ADDR_STAT, 32'h0004_004C);
    for (int i = 1; i <= 4; i++) rd(0, ADDR_RX, 32'(8'h90 + i));
    rd(0, ADDR_RX, 32'h0);
    rd(0, ADDR_STAT, 32'h0000_00D4);
    wr(0, ADDR_STAT, 32'hE0);
    rd(0, ADDR_STAT, 32'h0000_0014);

    // Flush during XFER with three words still queued.
    busy_len = 20;
    exp_l.push_back(32'hB1); resp_q.push_back(8'hC7);
    for (int i = 1; i <= 4; i++) wr(0, ADDR_TX, 32'(8'hB0 + i));
    wr(0, ADDR_CTRL, 32'h3);
    @(posedge clk); #1;
    rd(0, ADDR_STAT, 32'h0000_0015);
    tgt += 1; wait_n(0, tgt);
    rd(0, ADDR_STAT, 32'h0001_0004);
    rd(0, ADDR_RX, 32'hC7);
    rd(0, ADDR_CTRL, 32'h1);

    // rx_en = 0 discards the returned word.
    busy_len = 3;
    wr(0, ADDR_CTRL, 32'h0);
    exp_l.push_back(32'h5A); resp_q.push_back(8'hE1);
    wr(0, ADDR_TX, 32'h5A);
    tgt += 1; wait_n(0, tgt);
    rd(0, ADDR_STAT, 32'h0000_0014);
    wr(0, ADDR_CTRL, 32'h1);

    // 16-bit words through the wider instance, wrapping both FIFOs repeatedly.
    for (int b = 0; b < 5; b++) begin
      for (int k = 0; k < 4; k++) begin
        exp_l16.push_back({16'h0, word16(b * 4 + k)});
        wr(1, ADDR_TX, {16'hDEAD, word16(b * 4 + k)});
      end
      wait_n(1, 4 * (b + 1));
      for (int k = 0; k < 4; k++) rd(1, ADDR_RX, {16'h0, ~word16(b * 4 + k)});
    end
    rd(1, ADDR_STAT, 32'h0000_0014);

    // Reset in the middle of a transfer.
    busy_len = 10;
    exp_l.push_back(32'h77); resp_q.push_back(8'h66);
    wr(0, ADDR_TX, 32'h77);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_ready_send", {31'h0, spi_ready_send}, 0);
    check("midrst_data_in", {24'h0, spi_data_in}, 0);
    rd(0, ADDR_STAT, 32'h0000_0014);
    tgt += 1; wait_n(0, tgt);
    rd(0, ADDR_STAT, 32'h0000_0014);
    rd(0, ADDR_CTRL, 32'h1);

    repeat (2) @(posedge clk);
    #1;
    check("queues_drained", 32'(exp_rd.size() + exp_rd16.size() + exp_l.size() + exp_l16.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_ahb_fifo_bridge.md
# spi_ahb_fifo_bridge

AHB-slave-side bridge between the bus and the byte-serial SPI engine, successor to the single-register connector. It queues outgoing words in a TX FIFO, launches them into the SPI engine back-to-back using the engine's `ready_send` / `busy` handshake, and captures each returned word into an RX FIFO. Data width and both FIFO depths are parameters. Sticky status flags report overflow and underflow.

## Interface
- `DATA_W`, default 8: SPI word width, 1..16.
- `TX_DEPTH`, default 4: TX FIFO entries, power of two, ≥2.
- `RX_DEPTH`, default 4: RX FIFO entries, power of two, ≥2.
- `clk`  in  1: clock.
- `rst`  in  1: reset; synchronous, active-high; clock `clk`.
- `hsel`  in  1: slave select.
- `hwrite`  in  1: 1 = write, 0 = read.
- `haddr`  in  32: byte address; only `[3:0]` decoded, upper bits ignored.
- `hwdata`  in  32: write data.
- `hrdata`  out  32: read data, combinational.
- `spi_data_out`  in  DATA_W: word received by the SPI engine; valid when `spi_busy` falls.
- `spi_busy`  in  1: SPI engine transfer in progress.
- `spi_data_in`  out  DATA_W: word to transmit.
- `spi_ready_send`  out  1: launch request to the SPI engine.

## Operation
- Each cycle with `hsel` = 1 is exactly one access.
- Register map:
  - 0x0 TXDATA (W): push `hwdata[DATA_W-1:0]` to the TX FIFO. If the FIFO is full, the word is dropped and `tx_ovf` is set.
  - 0x4 RXDATA (R): `hrdata` = RX head, zero-extended, and the head is popped the same cycle. If the FIFO is empty, `hrdata` = 0 and `rx_udf` is set.
  - 0x8 STATUS (R): bit0 `busy` (FSM not IDLE), bit1 `tx_full`, bit2 `tx_empty`, bit3 `rx_full`, bit4 `rx_empty`, bit5 `tx_ovf`, bit6 `rx_ovf`, bit7 `rx_udf`, `[15:8]` `tx_count`, `[23:16]` `rx_count`, others 0. (W): writing 1 to bits 5..7 clears the corresponding flags.
  - 0xC CTRL (R/W): bit0 `rx_en` (reset value 1). Bit1 `flush` is write-only, self-clearing, and reads 0.
  - Unmapped address: reads return 0, writes are ignored.
- Launch FSM, states IDLE, LAUNCH, XFER:
  - IDLE → LAUNCH when the TX FIFO is non-empty and `spi_busy` = 0. On that edge: `spi_data_in` ← TX head, TX pop, `spi_ready_send` ← 1.
  - LAUNCH → XFER when `spi_busy` = 1. On that edge `spi_ready_send` ← 0.
  - XFER → IDLE when `spi_busy` = 0. On that edge, if `rx_en` = 1, `spi_data_out` is pushed to the RX FIFO. If the RX FIFO is full and not popped that cycle, the word is dropped and `rx_ovf` is set.
- Simultaneous events:
  - TX write and launch pop in the same cycle: fullness is evaluated before the pop, so a write to a full FIFO is dropped.
  - RX push and bus pop in the same cycle: both succeed, the count is unchanged, and the push is accepted even when full.
- Flush:
  - Empties both FIFOs the cycle after the write.
  - Does not abort LAUNCH or XFER.
  - The in-flight word is still captured after the flush.
  - A TXDATA write in the same cycle as flush is discarded.
- Pointer arithmetic:
  - Pointers are `$clog2(DEPTH)` bits and wrap naturally.
  - Counts are `$clog2(DEPTH)+1` bits.

## Timing
- Reset values:
  - `spi_ready_send` = 0, `spi_data_in` = 0.
  - FSM in IDLE, FIFOs empty, all flags 0, `rx_en` = 1.
  - `hrdata` reflects the reset state combinationally.
- TX write at edge N with the FSM idle and the engine idle: `spi_ready_send` = 1 after edge N+1.
- Back-to-back words: the next launch is 1 cycle after `spi_busy` falls.
- Data read at RXDATA is the word present before the edge; the pop takes effect at the edge.
- STATUS flags and counts update at the edge following the event.
- Reset mid-transfer:
  - All state is cleared.
  - A later fall of `spi_busy` is ignored because the FSM is already in IDLE.

## Structure
- Package `spi_bridge_pkg`:
  - Address constants `ADDR_TX`, `ADDR_RX`, `ADDR_STAT`, `ADDR_CTRL`.
  - FSM state enum.
  - STATUS bit-index constants.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH; ports push, pop, flush, full, empty, count, head) is instantiated twice, once for TX and once for RX.
- The top level contains the address decode, the FSM, the flags and the `hrdata` mux.

## Test plan
- Reset, then read STATUS: returns 0x0000_0014 (`tx_empty` = 1, `rx_empty` = 1).
- Write 0xA5 to 0x0; the model engine raises `spi_busy` for 8 cycles and returns 0x3C. Expected: `spi_data_in` = 0xA5, `ready_send` pulse ends on the busy rise, RXDATA reads 0x3C, then STATUS shows `rx_empty`.
- Write 5 words to TX (depth 4) while the engine is held busy: the 5th is dropped and `tx_ovf` = 1. Writing 0x20 to STATUS clears it. After release, 4 launches occur, each one cycle after the previous `busy` fall.
- Let 5 transfers complete with no reads (RX depth 4): `rx_ovf` = 1 and RX returns the first 4 words in order. A fifth read returns 0 and sets `rx_udf`.
- Issue the flush write during XFER with 3 words queued: TX empties, the in-flight word lands in RX, and `rx_count` = 1.
- Repeat with `DATA_W` = 16, `TX_DEPTH` = 8: 16-bit words pass intact and pointers wrap correctly across 20 transfers.
